fp_result_packer: RTL
=====================

FP_RESULT_PACKER -- requirements
Module: fp_result_packer

Interface
REQ-001 Parameter CNT_W, default 8: width of the result and exception counters.
REQ-002 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1: reset, synchronous and active-high.
REQ-004 Port in_valid, input, 1: upstream adder result present.
REQ-005 Port in_ready, output, 1: block accepts an input this cycle.
REQ-006 Port in_mant, input, 12: adder mantissa; bit 10 is the hidden-one position, bit 11 is the carry.
REQ-007 Port in_exp, input, 6: adder exponent, two's-complement wrapped; 0..32 positive, 33..63 mean in_exp-64.
REQ-008 Port in_sgn, input, 1: adder result sign.
REQ-009 Port out_valid, output, 1: packed result present.
REQ-010 Port out_ready, input, 1: downstream accepts the result.
REQ-011 Port out_data, output, 16: binary16 word {sign, exp[4:0], frac[9:0]}.
REQ-012 Port out_ovf / out_unf / out_zero, output, 1 each: classification flags travelling with out_data.
REQ-013 Port clr_cnt, input, 1: synchronous counter clear.
REQ-014 Port res_cnt / exc_cnt, output, CNT_W each: transferred-result count and exception count.

Function
REQ-015 An input transfer SHALL occur on in_valid&&in_ready; an output transfer SHALL occur on out_valid&&out_ready.
REQ-016 The pipeline SHALL have two register stages: S1 = classify, S2 = pack/output.
REQ-017 out_valid SHALL rise on the second clock edge after an input transfer when no stall occurs; sustained throughput SHALL be 1 result per cycle.
REQ-018 Pipeline advance rules: s2_adv = !out_valid || out_ready; in_ready = !s1_valid || s2_adv.
  - in_ready SHALL be combinational from state and out_ready only, never from in_valid.
REQ-019 While out_valid && !out_ready, out_data and all flags SHALL hold stable; no result SHALL be dropped or duplicated, and order SHALL be preserved.
REQ-020 S1 SHALL compute p, the leading-one index of in_mant (0..11), and a signed 8-bit exponent e:
  - p==11: e = E+1;
  - p==10: e = E;
  - p<10: e = E-(10-p);
  - where E is in_exp sign-interpreted per REQ-007.
REQ-021 frac SHALL be computed as follows, with truncation only and no rounding:
  - p==11: in_mant[10:1];
  - otherwise: the low 10 bits of in_mant<<(10-p).
REQ-022 Classification priority SHALL be zero > underflow > overflow > normal:
  - zero: in_mant==0;
  - underflow: e<=0;
  - overflow: e>=31.
REQ-023 Packing rules:
  - zero: out_data=16'h0000 (+0 forced), out_zero=1;
  - underflow: {in_sgn,15'h0}, out_unf=1;
  - overflow: {in_sgn,5'h1F,10'h0}, out_ovf=1;
  - normal: {in_sgn,e[4:0],frac}.
REQ-024 At most one of out_zero, out_unf, out_ovf SHALL be high for any result.
REQ-025 res_cnt SHALL increment by 1 on each output transfer and wrap at 2^CNT_W.
REQ-026 exc_cnt SHALL increment on each output transfer carrying out_ovf or out_unf, saturating at 2^CNT_W-1.
REQ-027 When clr_cnt coincides with an increment, the clear SHALL win and both counters SHALL read 0 next cycle.

Reset
REQ-028 With rst high at an edge, both stage-valid bits SHALL clear.
  - out_valid=0, out_data=0, out_ovf=0, out_unf=0, out_zero=0, res_cnt=0, exc_cnt=0.
REQ-029 Reset mid-operation SHALL discard all in-flight results without producing an output transfer.
REQ-030 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-031 in_mant=0x400, in_exp=15, in_sgn=0, out_ready=1 -> out_data=0x3C00 with out_valid on the 2nd edge after transfer, and res_cnt=1 once it transfers.
REQ-032 in_mant=0x800, in_exp=15 -> out_data=0x4000 (carry renormalised), no flags.
REQ-033 in_mant=0x401, in_exp=31, in_sgn=0 -> out_data=0x7C00, out_ovf=1, exc_cnt=1; in_mant=0x001, in_exp=5, in_sgn=1 -> out_data=0x8000, out_unf=1, exc_cnt=2.
REQ-034 in_mant=0x000, in_sgn=1 -> out_data=0x0000, out_zero=1, exc_cnt unchanged.
REQ-035 Backpressure case:
  - stimulus: out_ready=0 for 4 cycles while presenting 3 back-to-back valid inputs;
  - response: in_ready drops after 2 accepts, out_data holds, and all 3 results emerge in order once out_ready=1.
REQ-036 Counter and reset case:
  - stimulus: clr_cnt asserted on the same cycle as an output transfer; then rst asserted while S1 and S2 are full;
  - response: counters read 0; after reset, out_valid=0 and no stale result appears.

Source files
------------

// File: rtl/fp_result_packer_if.sv
// Handshake bundle between an FP adder, the result packer and the downstream consumer.
// The master side drives the adder result and the output back-pressure; the slave side
// (the packer) answers with acceptance and the packed binary16 result.
interface fp_result_packer_if;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_mant;
    logic [5:0]  in_exp;
    logic        in_sgn;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_ovf;
    logic        out_unf;
    logic        out_zero;

    modport master (
        output in_valid, in_mant, in_exp, in_sgn, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, out_unf, out_zero
    );

    modport slave (
        input  in_valid, in_mant, in_exp, in_sgn, out_ready,
        output in_ready, out_valid, out_data, out_ovf, out_unf, out_zero
    );
endinterface

// File: rtl/fp_result_packer.sv
// Two-stage packer turning a raw adder result (12-bit mantissa with carry, wrapped
// 6-bit exponent) into a truncated binary16 word with zero/underflow/overflow flags.
// S1 normalises and classifies, S2 packs and presents the result; a result counter
// and a saturating exception counter track completed output transfers.
module fp_result_packer #(
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    fp_result_packer_if.slave    bus,
    input  logic                 clr_cnt,
    output logic [CNT_W-1:0]     res_cnt,
    output logic [CNT_W-1:0]     exc_cnt
);

    // Index of the most significant set bit; 0 when the mantissa is empty
    // (the zero class overrides everything derived from it).
    function automatic logic [3:0] lead_one(input logic [11:0] m);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 12; i++) begin
            idx = m[i] ? 4'(i) : idx;
        end
        return idx;
    endfunction

    // Stage 1 registers: classified, normalised fields
    logic        r_s1_valid;
    logic        r_s1_sgn;
    logic        r_s1_zero;
    logic        r_s1_unf;
    logic        r_s1_ovf;
    logic [4:0]  r_s1_exp;
    logic [9:0]  r_s1_frac;

    // Stage 2 registers: the presented result
    logic        r_out_valid;
    logic [15:0] r_out_data;
    logic        r_out_ovf;
    logic        r_out_unf;
    logic        r_out_zero;

    logic [CNT_W-1:0] r_res_cnt;
    logic [CNT_W-1:0] r_exc_cnt;

    logic              w_s2_adv;
    logic              w_in_ready;
    logic              w_out_fire;
    logic [3:0]        w_p;
    logic [3:0]        w_shamt;
    logic signed [7:0] w_e_base;
    logic signed [7:0] w_e;
    logic [9:0]        w_frac;
    logic [9:0]        w_frac_sh;
    logic              w_zero;
    logic              w_unf;
    logic              w_ovf;
    logic [15:0]       w_pack;

    // Output stage moves whenever it is empty or its result is being taken;
    // the input side only looks at state and out_ready.
    assign w_s2_adv   = !r_out_valid || bus.out_ready;
    assign w_in_ready = !r_s1_valid || w_s2_adv;
    assign w_out_fire = r_out_valid && bus.out_ready;

    assign w_p       = lead_one(bus.in_mant);
    assign w_shamt   = 4'd10 - w_p;
    assign w_frac_sh = 10'(bus.in_mant << w_shamt);
    // Exponent codes 0..32 are positive, 33..63 stand for code-64.
    assign w_e_base  = (bus.in_exp > 6'd32) ? {2'b11, bus.in_exp} : {2'b00, bus.in_exp};

    // Normalise: a carry shifts right by one, otherwise shift the leading one up to bit 10
    always_comb begin
        w_e    = w_e_base;
        w_frac = w_frac_sh;
        if (w_p == 4'd11) begin
            w_e    = w_e_base + 8'sd1;
            w_frac = bus.in_mant[10:1];
        end else begin
            w_e    = w_e_base - {4'd0, w_shamt};
            w_frac = w_frac_sh;
        end
    end

    assign w_zero = (bus.in_mant == 12'd0);
    assign w_unf  = (w_e <= 8'sd0);
    assign w_ovf  = (w_e >= 8'sd31);

    // Build the binary16 word from the stage-1 class; zero always packs as +0
    always_comb begin
        w_pack = 16'h0000;
        if (r_s1_zero) begin
            w_pack = 16'h0000;
        end else if (r_s1_unf) begin
            w_pack = {r_s1_sgn, 15'h0000};
        end else if (r_s1_ovf) begin
            w_pack = {r_s1_sgn, 5'h1F, 10'h000};
        end else begin
            w_pack = {r_s1_sgn, r_s1_exp, r_s1_frac};
        end
    end

    // Stage 1: capture the classified input whenever the stage can accept
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sgn   <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_unf   <= 1'b0;
            r_s1_ovf   <= 1'b0;
            r_s1_exp   <= 5'd0;
            r_s1_frac  <= 10'd0;
        end else if (w_in_ready) begin
            r_s1_valid <= bus.in_valid;
            r_s1_sgn   <= bus.in_sgn;
            r_s1_zero  <= w_zero;
            r_s1_unf   <= !w_zero && w_unf;
            r_s1_ovf   <= !w_zero && !w_unf && w_ovf;
            r_s1_exp   <= w_e[4:0];
            r_s1_frac  <= w_frac;
        end
    end

    // Stage 2: load the packed word when advancing, otherwise hold it stable
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= 16'h0000;
            r_out_ovf   <= 1'b0;
            r_out_unf   <= 1'b0;
            r_out_zero  <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_pack;
                r_out_ovf  <= r_s1_ovf;
                r_out_unf  <= r_s1_unf;
                r_out_zero <= r_s1_zero;
            end
        end
    end

    // Transfer counters: clear beats increment, exception count saturates
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            r_res_cnt <= {CNT_W{1'b0}};
            r_exc_cnt <= {CNT_W{1'b0}};
        end else if (w_out_fire) begin
            r_res_cnt <= r_res_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if ((r_out_ovf || r_out_unf) && (r_exc_cnt != {CNT_W{1'b1}})) begin
                r_exc_cnt <= r_exc_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_ovf   = r_out_ovf;
    assign bus.out_unf   = r_out_unf;
    assign bus.out_zero  = r_out_zero;
    assign res_cnt       = r_res_cnt;
    assign exc_cnt       = r_exc_cnt;

endmodule
